// File: rtl/cdb_arbiter_if.sv
// Result-collection and common-data-bus signals of the CDB arbiter.
// master: the arbiter itself; slave: execution units plus bus listeners.
interface cdb_arbiter_if #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5
);
    localparam int UW = $clog2(UNITS);

    logic [UNITS-1:0]                  result_valid;
    logic [UNITS-1:0]                  result_ready;
    logic [UNITS-1:0][RS_ID_WIDTH-1:0] result_rs_id;
    logic [UNITS-1:0][31:0]            result_value;

    logic                   cdb_valid;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id;
    logic [31:0]            cdb_value;
    logic [UW-1:0]          cdb_unit;

    modport master (
        input  result_valid, result_rs_id, result_value,
        output result_ready, cdb_valid, cdb_rs_id, cdb_value, cdb_unit
    );

    modport slave (
        output result_valid, result_rs_id, result_value,
        input  result_ready, cdb_valid, cdb_rs_id, cdb_value, cdb_unit
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-unit result FIFOs, round-robin grant (fixed priority when CDB_FIXED_PRIORITY_EN is defined).
// Latency: a result accepted at edge N is broadcast in cycle N+2 at the earliest.
// Backpressure: result_ready drops only when that unit's FIFO is full; the bus itself is never stalled.
module cdb_arbiter #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.master bus
);
    localparam int UW = $clog2(UNITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = RS_ID_WIDTH + 32;
    localparam logic [UW:0] UNITS_W = (UW+1)'(UNITS);

    logic [DW-1:0]    mem    [UNITS][FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr [UNITS];
    logic [PW-1:0]    rd_ptr [UNITS];
    logic [CW-1:0]    count  [UNITS];
    logic [UNITS-1:0] push;
    logic [UNITS-1:0] pop;
    logic [UW-1:0]    rr_ptr;
    logic [UW-1:0]    grant;
    logic             grant_vld;
    logic [UW:0]      idx;
    logic [DW-1:0]    head;

    // Ready is a function of registered occupancy only, so a full FIFO stays closed even while popping.
    always_comb begin
        for (int u = 0; u < UNITS; u++) begin
            bus.result_ready[u] = ~rst && (count[u] != CW'(FIFO_DEPTH));
            push[u]             = bus.result_valid[u] && bus.result_ready[u];
            pop[u]              = grant_vld && (grant == UW'(u));
        end
    end

    // First non-empty FIFO at or after rr_ptr, wrapping modulo UNITS.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int i = 0; i < UNITS; i++) begin
            idx = {1'b0, rr_ptr} + (UW+1)'(i);
            if (idx >= UNITS_W) idx = idx - UNITS_W;
            if (!grant_vld && (count[idx[UW-1:0]] != '0)) begin
                grant_vld = 1'b1;
                grant     = idx[UW-1:0];
            end
        end
    end

    assign head = mem[grant][rd_ptr[grant]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < UNITS; u++) begin
                wr_ptr[u] <= '0;
                rd_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            for (int u = 0; u < UNITS; u++) begin
                if (push[u]) begin
                    mem[u][wr_ptr[u]] <= {bus.result_rs_id[u], bus.result_value[u]};
                    wr_ptr[u]         <= wr_ptr[u] + 1'b1;
                end
                if (pop[u]) rd_ptr[u] <= rd_ptr[u] + 1'b1;
                case ({push[u], pop[u]})
                    2'b10:   count[u] <= count[u] + 1'b1;
                    2'b01:   count[u] <= count[u] - 1'b1;
                    default: count[u] <= count[u];
                endcase
            end
        end
    end

`ifdef CDB_FIXED_PRIORITY_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant == UW'(UNITS - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    // Tag, value and unit hold their last broadcast while idle; only cdb_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_rs_id <= '0;
            bus.cdb_value <= '0;
            bus.cdb_unit  <= '0;
        end else begin
            bus.cdb_valid <= grant_vld;
            if (grant_vld) begin
                bus.cdb_rs_id <= head[DW-1:32];
                bus.cdb_value <= head[31:0];
                bus.cdb_unit  <= grant;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: scoreboard of expected broadcasts plus cycle-exact timing checks.
module tb_cdb_arbiter;
    localparam int UNITS = 4;
    localparam int RSW   = 5;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cdb_arbiter_if #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) bus ();

    cdb_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] val;
        logic [1:0]  unit;
    } bc_t;

    bc_t sb[$];
    bc_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_bc(input logic [4:0] id, input logic [31:0] val, input logic [1:0] unit);
        bc_t e;
        e.id   = id;
        e.val  = val;
        e.unit = unit;
        sb.push_back(e);
    endfunction

    // Every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_bcast", 64'(bus.cdb_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("bc_rs_id", 64'(bus.cdb_rs_id), 64'(mon_e.id));
                chk("bc_value", 64'(bus.cdb_value), 64'(mon_e.val));
                chk("bc_unit",  64'(bus.cdb_unit),  64'(mon_e.unit));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_ready", 64'(bus.result_ready), 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.result_ready), 64'hF);
        chk("post_rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("post_rst_id",    64'(bus.cdb_rs_id), 64'd0);
        chk("post_rst_value", 64'(bus.cdb_value), 64'd0);
        chk("post_rst_unit",  64'(bus.cdb_unit),  64'd0);
        tick();
    endtask

    // Holds one result on unit u until accepted; waited counts cycles spent not ready.
    task automatic offer(input int u, input logic [4:0] id, input logic [31:0] v, output int waited);
        bit acc;
        bit r;
        acc    = 1'b0;
        waited = 0;
        bus.result_valid[u] = 1'b1;
        bus.result_rs_id[u] = id;
        bus.result_value[u] = v;
        for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge clk);
            r = bus.result_ready[u];
            tick();
            if (r) acc = 1'b1;
            else   waited++;
        end
        bus.result_valid[u] = 1'b0;
        chk("offer_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        int waited;
        bus.result_valid = '0;
        bus.result_rs_id = '0;
        bus.result_value = '0;

        do_reset();

        // Single result, exact two-cycle latency and one-cycle pulse.
        exp_bc(5'd5, 32'hDEADBEEF, 2'd1);
        bus.result_valid[1] = 1'b1;
        bus.result_rs_id[1] = 5'd5;
        bus.result_value[1] = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_ready1", 64'(bus.result_ready[1]), 64'd1);
        tick();
        bus.result_valid[1] = 1'b0;
        @(negedge clk);
        chk("t1_n1_valid", 64'(bus.cdb_valid), 64'd0);
        @(negedge clk);
        chk("t1_n2_valid", 64'(bus.cdb_valid), 64'd1);
        @(negedge clk);
        chk("t1_n3_valid", 64'(bus.cdb_valid), 64'd0);
        wait_drain();

        // Simultaneous results on all units from rr_ptr = 0.
        do_reset();
        for (int u = 0; u < UNITS; u++) begin
            bus.result_valid[u] = 1'b1;
            bus.result_rs_id[u] = 5'(u * 8);
            bus.result_value[u] = 32'h1111_0000 + 32'(u);
            exp_bc(5'(u * 8), 32'h1111_0000 + 32'(u), 2'(u));
        end
        tick();
        bus.result_valid = '0;
        @(negedge clk);
        chk("t2_gap_valid", 64'(bus.cdb_valid), 64'd0);
        for (int i = 0; i < UNITS; i++) begin
            @(negedge clk);
            chk("t2_b2b_valid", 64'(bus.cdb_valid), 64'd1);
        end
        @(negedge clk);
        chk("t2_end_valid", 64'(bus.cdb_valid), 64'd0);
        wait_drain();

        // Lone unit 2 moves the pointer to 3, so unit 3 then beats unit 0 under round-robin.
        exp_bc(5'd3, 32'hC2C2_C2C2, 2'd2);
        offer(2, 5'd3, 32'hC2C2_C2C2, waited);
        wait_drain();
`ifdef CDB_FIXED_PRIORITY_EN
        exp_bc(5'd9,  32'h0000_0A00, 2'd0);
        exp_bc(5'd12, 32'h0000_0A03, 2'd3);
`else
        exp_bc(5'd12, 32'h0000_0A03, 2'd3);
        exp_bc(5'd9,  32'h0000_0A00, 2'd0);
`endif
        bus.result_valid[0] = 1'b1;
        bus.result_rs_id[0] = 5'd9;
        bus.result_value[0] = 32'h0000_0A00;
        bus.result_valid[3] = 1'b1;
        bus.result_rs_id[3] = 5'd12;
        bus.result_value[3] = 32'h0000_0A03;
        tick();
        bus.result_valid = '0;
        wait_drain();

        // Fairness: unit 0 streams six results while unit 2 offers one.
        do_reset();
        exp_bc(5'd1, 32'hA000_0000, 2'd0);
`ifndef CDB_FIXED_PRIORITY_EN
        exp_bc(5'd20, 32'hB0B0_0002, 2'd2);
`endif
        for (int k = 1; k < 6; k++) exp_bc(5'(k + 1), 32'hA000_0000 + 32'(k), 2'd0);
`ifdef CDB_FIXED_PRIORITY_EN
        exp_bc(5'd20, 32'hB0B0_0002, 2'd2);
`endif
        bus.result_valid[2] = 1'b1;
        bus.result_rs_id[2] = 5'd20;
        bus.result_value[2] = 32'hB0B0_0002;
        for (int k = 0; k < 6; k++) begin
            offer(0, 5'(k + 1), 32'hA000_0000 + 32'(k), waited);
            if (k == 0) bus.result_valid[2] = 1'b0;
        end
        wait_drain();

        // Full FIFO on unit 3: third result is held until unit 3's head is popped.
        do_reset();
`ifdef CDB_FIXED_PRIORITY_EN
        for (int u = 0; u < UNITS; u++) begin
            exp_bc(5'(u * 4),     32'hF000_0000 + 32'(u * 16),     2'(u));
            exp_bc(5'(u * 4 + 1), 32'hF000_0000 + 32'(u * 16 + 1), 2'(u));
        end
`else
        for (int j = 0; j < 2; j++)
            for (int u = 0; u < UNITS; u++)
                exp_bc(5'(u * 4 + j), 32'hF000_0000 + 32'(u * 16 + j), 2'(u));
`endif
        exp_bc(5'd30, 32'hF000_0032, 2'd3);
        for (int j = 0; j < 2; j++) begin
            for (int u = 0; u < UNITS; u++) begin
                bus.result_valid[u] = 1'b1;
                bus.result_rs_id[u] = 5'(u * 4 + j);
                bus.result_value[u] = 32'hF000_0000 + 32'(u * 16 + j);
            end
            @(negedge clk);
            chk("t4_ready_all", 64'(bus.result_ready), 64'hF);
            tick();
        end
        bus.result_valid = '0;
        offer(3, 5'd30, 32'hF000_0032, waited);
`ifdef CDB_FIXED_PRIORITY_EN
        chk("t4_full_wait", 64'(waited), 64'd6);
`else
        chk("t4_full_wait", 64'(waited), 64'd3);
`endif
        wait_drain();

        // Pointer wrap: five results through unit 0 back to back.
        for (int k = 0; k < 5; k++) exp_bc(5'(k), 32'h5A5A_0000 + 32'(k), 2'd0);
        for (int k = 0; k < 5; k++) begin
            offer(0, 5'(k), 32'h5A5A_0000 + 32'(k), waited);
            chk("t5_no_wait", 64'(waited), 64'd0);
        end
        wait_drain();

        // Reset with three results buffered: all of them must vanish.
        for (int u = 0; u < 3; u++) begin
            bus.result_valid[u] = 1'b1;
            bus.result_rs_id[u] = 5'(u + 17);
            bus.result_value[u] = 32'h7777_0000 + 32'(u);
        end
        tick();
        bus.result_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t6_rst_ready", 64'(bus.result_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("t6_rst_valid2", 64'(bus.cdb_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_stale", 64'(bus.cdb_valid), 64'd0);
        end
        chk("t6_ready_after", 64'(bus.result_ready), 64'hF);
        tick();
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
